// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: finds the ARM data-processing immediate (imm8, rot4) for a
// 32-bit constant, so that value == ROR(imm8, 2*rot4). One rotation is tried
// per cycle. The smallest rotation that fits is reported; otherwise found=0.
module imm_rot_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [7:0]  imm8,
  output logic [3:0]  rot4
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ImmW  = 8;
  localparam int unsigned RotW  = 4;
  localparam int unsigned ShW   = 5;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SEARCH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [RotW-1:0]   k_q, k_d;
  logic [DataW-1:0]  val_q, val_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [ImmW-1:0]   imm8_q, imm8_d;
  logic [RotW-1:0]   rot4_q, rot4_d;

  logic [ShW-1:0]    sh;
  logic [DataW-1:0]  cand;
  logic              hit;

  // Candidate for the current k: rotate the captured value left by 2*k.
  // A right shift by 32 (k=0) yields zero, so the OR reduces to val_q.
  always_comb begin
    sh   = {k_q, 1'b0};
    cand = (val_q << sh) | (val_q >> (6'd32 - 6'(sh)));
    hit  = (cand[DataW-1:ImmW] == '0);
  end

  // Next-state and result logic; results only change on the done cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    val_d   = val_q;
    done_d  = 1'b0;
    found_d = found_q;
    imm8_d  = imm8_q;
    rot4_d  = rot4_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d   = value;
          k_d     = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (hit) begin
          found_d = 1'b1;
          imm8_d  = cand[ImmW-1:0];
          rot4_d  = k_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (k_q == RotW'(15)) begin
          found_d = 1'b0;
          imm8_d  = '0;
          rot4_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d = k_q + RotW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any search in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      imm8_q  <= '0;
      rot4_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      val_q   <= val_d;
      done_q  <= done_d;
      found_q <= found_d;
      imm8_q  <= imm8_d;
      rot4_q  <= rot4_d;
    end
  end

  // Outputs straight from flops.
  always_comb begin
    busy  = (state_q == S_SEARCH);
    done  = done_q;
    found = found_q;
    imm8  = imm8_q;
    rot4  = rot4_q;
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed self-checking bench for imm_rot_encoder.
module tb_imm_rot_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  imm8;
  logic [3:0]  rot4;

  int total = 0;
  int bad   = 0;

  logic [12:0] prev_res;

  typedef struct {
    logic [31:0] v;
    logic        f;
    logic [7:0]  i8;
    logic [3:0]  r4;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  imm_rot_encoder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .found (found),
    .imm8  (imm8),
    .rot4  (rot4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; the following posedge becomes E0.
  task automatic launch(input logic [31:0] v);
    start = 1'b1;
    value = v;
  endtask

  // Follows one operation from E0 to its done cycle. m counts negedges after
  // E0; done is expected at m == latency (k+2, or 17 on a miss).
  task automatic wait_done(input logic [31:0] v, input logic ef, input logic [7:0] ei,
                           input logic [3:0] er, input int elat, input int inj_at,
                           input bit hold);
    int m;
    bit seen;
    bit busy_ok;
    m = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    @(posedge clk);
    while (!seen && m < 40) begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        if (!hold) start = 1'b0;
        check("hold_result", 32'({found, imm8, rot4}), 32'(prev_res));
      end
      if (inj_at > 0 && m == inj_at) begin
        start = 1'b1;
        value = 32'h0000_00FF;
      end
      if (inj_at > 0 && m == inj_at + 1) begin
        start = 1'b0;
        value = v;
      end
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check($sformatf("latency_%h", v), 32'(m), 32'(elat));
    check("busy_during", 32'(busy_ok), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check($sformatf("found_%h", v), 32'(found), 32'(ef));
    check($sformatf("imm8_%h", v), 32'(imm8), 32'(ei));
    check($sformatf("rot4_%h", v), 32'(rot4), 32'(er));
    prev_res = {ef, ei, er};
  endtask

  initial begin
    int n_done;

    vecs[0] = '{32'h0000_00FF, 1'b1, 8'hFF, 4'd0,  2};
    vecs[1] = '{32'hFF00_0000, 1'b1, 8'hFF, 4'd4,  6};
    vecs[2] = '{32'hF000_000F, 1'b1, 8'hFF, 4'd2,  4};
    vecs[3] = '{32'h0000_03FC, 1'b1, 8'hFF, 4'd15, 17};
    vecs[4] = '{32'h0000_0101, 1'b0, 8'h00, 4'd0,  17};
    vecs[5] = '{32'h0000_00F0, 1'b1, 8'hF0, 4'd0,  2};
    vecs[6] = '{32'h0000_0000, 1'b1, 8'h00, 4'd0,  2};
    vecs[7] = '{32'hAB00_0000, 1'b1, 8'hAB, 4'd4,  6};
    vecs[8] = '{32'h0003_FC00, 1'b1, 8'hFF, 4'd11, 13};
    vecs[9] = '{32'h8000_0001, 1'b1, 8'h06, 4'd1,  3};

    reset = 1'b0;
    start = 1'b0;
    value = 32'h0;
    prev_res = '0;
    #12;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_out",   32'({found, imm8, rot4}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table run, every operation launched back-to-back in the previous done cycle.
    launch(vecs[0].v);
    for (int i = 0; i < 10; i++) begin
      wait_done(vecs[i].v, vecs[i].f, vecs[i].i8, vecs[i].r4, vecs[i].lat, 0, 1'b0);
      if (i < 9) launch(vecs[i+1].v);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);

    // start during a search is ignored and not queued.
    launch(32'h0000_0101);
    wait_done(32'h0000_0101, 1'b0, 8'h00, 4'd0, 17, 3, 1'b0);
    @(negedge clk);
    check("no_queued_start", 32'(busy), 32'd0);

    // start held high restarts on every done cycle.
    launch(32'h0000_00FF);
    wait_done(32'h0000_00FF, 1'b1, 8'hFF, 4'd0, 2, 0, 1'b1);
    wait_done(32'h0000_00FF, 1'b1, 8'hFF, 4'd0, 2, 0, 1'b0);
    @(negedge clk);
    check("held_start_stop", 32'(busy), 32'd0);

    // Asynchronous reset mid-search.
    launch(32'h0000_03FC);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out",  32'({found, imm8, rot4}), 32'd0);
    prev_res = '0;
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("arst_no_done", 32'(n_done), 32'd0);
    launch(32'hFF00_0000);
    wait_done(32'hFF00_0000, 1'b1, 8'hFF, 4'd4, 6, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
